stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised CH-to-1, N-bit registered stream multiplexer; successor to static select muxes.
//  Channels present data with valid/ready handshakes; a round-robin arbiter picks one per cycle.
//  The winner is registered into a single output stage tagged with its channel index.
//  Used to merge requesters (e.g. memory/IO ports) onto one shared datapath.
// PARAMETERS
//  N      32  data width per channel, bits
//  CH     4   number of input channels, >=2; need not be a power of two
//  SEL_W  2   channel-index width; must satisfy 2**SEL_W >= CH
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  in_data    in   CH*N    channel i data at [i*N +: N]
//  in_valid   in   CH      channel i offers data
//  in_ready   out  CH      channel i transfer happens this cycle if in_valid[i]
//  out_data   out  N       registered selected data
//  out_sel    out  SEL_W   channel index of out_data
//  out_valid  out  1       out_data/out_sel valid
//  out_ready  in   1       downstream accepts
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0; in_ready=0 while rst.
//  - space = !out_valid || out_ready. Combinational; output stage can load this cycle.
//  - grant: one-hot, combinational. Scan channels ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
//    First channel with in_valid=1 wins. grant=0 if no channel is valid.
//  - in_ready = grant & {CH{space}}. At most one bit set.
//    in_ready may depend on in_valid (arbitration); sources must not wait for in_ready before asserting valid.
//  - accept = |(in_valid & in_ready). On accept at clock edge:
//    out_data<=winner data, out_sel<=winner idx, out_valid<=1.
//    ptr<=idx+1; idx=CH-1 wraps ptr to 0.
//  - No accept and out_valid && out_ready: out_valid<=0; out_data/out_sel hold their last value.
//  - No accept and out_valid && !out_ready: all outputs hold; in_ready=0.
//  - Simultaneous drain and fill (out_valid && out_ready && accept): new word loads, out_valid stays 1.
//    Full throughput is 1 word/cycle.
//  - Latency: input transfer at edge k appears on out_data after edge k (1 cycle).
//  - ptr updates only on accept. Idle cycles do not advance it.
//  - Fairness: a continuously valid channel is granted within CH accepts.
//  - rst asserted mid-transfer: pending output word is dropped, ptr returns to 0.
//    Sources must re-offer any word that was not accepted.
// CONFIGURATION
//  Macro STREAM_MUX_FORCE_SEL_EN.
//  - Defined: adds ports force_en (in, 1) and force_sel (in, SEL_W).
//    When force_en=1, grant is one-hot on force_sel only, gated by in_valid[force_sel].
//    Other channels get in_ready=0. ptr does not update while force_en=1.
//    force_sel>=CH grants nothing.
//  - Undefined: ports absent; pure round-robin as above.
// TESTING
//  1 Reset: rst=1 mid-stream -> out_valid=0, out_sel=0, out_data=0 asynchronously; first grant after release is ch0.
//  2 All 4 valid, out_ready=1, data ch i = 32'hA0+i.
//    -> out_sel 0,1,2,3,0 on consecutive cycles; out_data 32'hA0..A3,A0.
//  3 out_valid=1, out_ready=0 for 3 cycles, all inputs valid
//    -> in_ready=4'b0000, out_data/out_sel stable; resumes in rr order when out_ready=1.
//  4 Only ch2 valid, out_ready=1 -> in_ready=4'b0100 every cycle; one word per cycle, out_sel=2.
//  5 Wrap: last grant ch2 (ptr=3), valid on ch0 and ch3 -> ch3 granted, then ch0.
//  6 With STREAM_MUX_FORCE_SEL_EN: force_en=1, force_sel=1, all valid
//    -> only ch1 accepted, ptr unchanged; force_sel=3'd5 with CH=4, SEL_W=3 -> no grant.

Source files
------------

// File: rtl/stream_mux_rr.sv
// CH-to-1 registered stream multiplexer with a round-robin arbiter and a channel-index tag.
// Optional macro STREAM_MUX_FORCE_SEL_EN adds force_en/force_sel to pin the grant to one channel.
module stream_mux_rr #(
    parameter int N     = 32,
    parameter int CH    = 4,
    parameter int SEL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*N-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
`ifdef STREAM_MUX_FORCE_SEL_EN
    input  logic              force_en,
    input  logic [SEL_W-1:0]  force_sel,
`endif
    output logic [N-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;
    logic [N-1:0]     data_reg;
    logic [N-1:0]     data_next;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] sel_next;
    logic             valid_reg;
    logic             valid_next;

    logic             space;
    logic             accept;
    logic             ptr_upd;
    logic [CH-1:0]    hi_mask;
    logic [CH-1:0]    hi_req;
    logic [CH-1:0]    rr_req;
    logic [CH-1:0]    grant_rr;
    logic [CH-1:0]    grant;
    logic [SEL_W-1:0] win_idx;
    logic [N-1:0]     win_data;

    // OR-chains collapse the one-hot grant into an index and a data word.
    logic [SEL_W-1:0] idx_chain  [CH+1];
    logic [N-1:0]     data_chain [CH+1];

    assign space = !valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_mask
            assign hi_mask[gi] = (SEL_W'(gi) >= ptr_reg);
        end
    endgenerate

    // Requests at or above ptr take priority; if none, wrap to the lowest valid channel.
    assign hi_req   = in_valid & hi_mask;
    assign rr_req   = (|hi_req) ? hi_req : in_valid;
    assign grant_rr = rr_req & (~rr_req + CH'(1));

`ifdef STREAM_MUX_FORCE_SEL_EN
    logic [CH-1:0] force_hit;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_force
            assign force_hit[gi] = (force_sel == SEL_W'(gi));
        end
    endgenerate

    // A force_sel outside the channel range matches no bit and so grants nothing.
    assign grant   = force_en ? (in_valid & force_hit) : grant_rr;
    assign ptr_upd = accept && !force_en;
`else
    assign grant   = grant_rr;
    assign ptr_upd = accept;
`endif

    assign idx_chain[0]  = '0;
    assign data_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_enc
            assign idx_chain[gi+1]  = idx_chain[gi]  | (grant[gi] ? SEL_W'(gi) : '0);
            assign data_chain[gi+1] = data_chain[gi] | (grant[gi] ? in_data[gi*N +: N] : '0);
        end
    endgenerate

    assign win_idx  = idx_chain[CH];
    assign win_data = data_chain[CH];

    // Reset holds every channel off so no source believes a transfer happened.
    assign in_ready = rst ? '0 : (grant & {CH{space}});
    assign accept   = |(in_valid & in_ready);

    always_comb begin
        ptr_next   = ptr_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        if (accept) begin
            data_next  = win_data;
            sel_next   = win_idx;
            valid_next = 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
        if (ptr_upd) begin
            ptr_next = (win_idx == SEL_W'(CH - 1)) ? '0 : win_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            data_reg  <= '0;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
        end
    end

    assign out_data  = data_reg;
    assign out_sel   = sel_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, round-robin order, backpressure, wrap, idle, force select.
module tb_stream_mux_rr;

    localparam int N  = 32;
    localparam int CH = 4;
`ifdef STREAM_MUX_FORCE_SEL_EN
    localparam int SEL_W = 3;
`else
    localparam int SEL_W = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH*N-1:0]   in_data = '0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     in_ready;
    logic [N-1:0]      out_data;
    logic [SEL_W-1:0]  out_sel;
    logic              out_valid;
    logic              out_ready = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
    logic              force_en = 1'b0;
    logic [SEL_W-1:0]  force_sel = '0;
`endif

    int checks   = 0;
    int failures = 0;

    stream_mux_rr #(.N(N), .CH(CH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef STREAM_MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
        force_en = 1'b0;
        force_sel = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [SEL_W-1:0] exp_sel;
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_init_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_init_data got=%h exp=0", out_data); end
        checks++; if (out_sel !== '0) begin failures++; $display("FAIL reset_init_sel got=%0d exp=0", out_sel); end
        in_valid = 4'b1111;
        out_ready = 1'b1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("reset: streamed sel=%0d data=%h before mid-stream reset", out_sel, out_data);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_valid got=%b exp=0", out_valid); end
        checks++; if (out_sel !== '0) begin failures++; $display("FAIL reset_mid_sel got=%0d exp=0", out_sel); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_mid_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_mid_in_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
        @(negedge clk);
        exp_sel = '0;
        checks++; if (out_sel !== exp_sel || out_data !== 32'hA0) begin failures++; $display("FAIL reset_first_word got sel=%0d data=%h exp sel=0 data=a0", out_sel, out_data); end
        in_valid = '0;
    endtask

    task automatic test_rr_order();
        logic [SEL_W-1:0] exp_sel;
        logic [CH-1:0]    exp_rdy;
        do_reset();
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_rdy = 4'b0001 << (i % 4);
            exp_sel = SEL_W'(i % 4);
            #1;
            checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
            @(negedge clk);
            $display("rr: word %0d sel=%0d data=%h valid=%b", i, out_sel, out_data, out_valid);
            checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== 32'hA0 + 32'(i % 4)) begin
                failures++; $display("FAIL rr_word[%0d] got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h", i, out_valid, out_sel, out_data, exp_sel, 32'hA0 + 32'(i % 4));
            end
        end
        in_valid = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 32'hA0) begin failures++; $display("FAIL rr_drain got v=%b data=%h exp v=0 data=a0", out_valid, out_data); end
    endtask

    task automatic test_backpressure();
        logic [SEL_W-1:0] exp_sel;
        do_reset();
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid = 4'b1111;
        out_ready = 1'b0;
        @(negedge clk);
        exp_sel = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("bp: stall %0d sel=%0d data=%h in_ready=%b", i, out_sel, out_data, in_ready);
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== 32'hA0) begin
                failures++; $display("FAIL bp_hold[%0d] got v=%b sel=%0d data=%h exp v=1 sel=0 data=a0", i, out_valid, out_sel, out_data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_resume_ready got=%b exp=0010", in_ready); end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            exp_sel = SEL_W'(i);
            checks++; if (out_sel !== exp_sel || out_data !== 32'hA0 + 32'(i)) begin
                failures++; $display("FAIL bp_resume[%0d] got sel=%0d data=%h exp sel=%0d data=%h", i, out_sel, out_data, exp_sel, 32'hA0 + 32'(i));
            end
        end
        in_valid = '0;
    endtask

    task automatic test_single_channel();
        logic [SEL_W-1:0] exp_sel;
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b0100;
        exp_sel = SEL_W'(2);
        for (int i = 0; i < 4; i++) begin
            in_data = {32'h0, 32'hB0 + 32'(i), 32'h0, 32'h0};
            #1;
            checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready[%0d] got=%b exp=0100", i, in_ready); end
            @(negedge clk);
            $display("single: word %0d sel=%0d data=%h", i, out_sel, out_data);
            checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== 32'hB0 + 32'(i)) begin
                failures++; $display("FAIL single_word[%0d] got v=%b sel=%0d data=%h exp v=1 sel=2 data=%h", i, out_valid, out_sel, out_data, 32'hB0 + 32'(i));
            end
        end
        in_valid = '0;
    endtask

    task automatic test_wrap();
        logic [SEL_W-1:0] exp_sel;
        do_reset();
        out_ready = 1'b1;
        in_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        in_valid = 4'b0100;
        @(negedge clk);
        in_valid = 4'b1001;
        #1;
        checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL wrap_first_ready got=%b exp=1000", in_ready); end
        @(negedge clk);
        exp_sel = SEL_W'(3);
        $display("wrap: sel=%0d data=%h", out_sel, out_data);
        checks++; if (out_sel !== exp_sel || out_data !== 32'hC3) begin failures++; $display("FAIL wrap_first got sel=%0d data=%h exp sel=3 data=c3", out_sel, out_data); end
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL wrap_second_ready got=%b exp=0001", in_ready); end
        @(negedge clk);
        exp_sel = '0;
        $display("wrap: sel=%0d data=%h", out_sel, out_data);
        checks++; if (out_sel !== exp_sel || out_data !== 32'hC0) begin failures++; $display("FAIL wrap_second got sel=%0d data=%h exp sel=0 data=c0", out_sel, out_data); end
        in_valid = '0;
    endtask

    task automatic test_idle_ptr();
        logic [SEL_W-1:0] exp_sel;
        do_reset();
        out_ready = 1'b1;
        in_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        in_valid = 4'b0010;
        @(negedge clk);
        in_valid = '0;
        repeat (3) @(negedge clk);
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL idle_ptr_ready got=%b exp=0100", in_ready); end
        @(negedge clk);
        exp_sel = SEL_W'(2);
        $display("idle: sel=%0d data=%h", out_sel, out_data);
        checks++; if (out_sel !== exp_sel || out_data !== 32'hD2) begin failures++; $display("FAIL idle_ptr_word got sel=%0d data=%h exp sel=2 data=d2", out_sel, out_data); end
        in_valid = '0;
    endtask

`ifdef STREAM_MUX_FORCE_SEL_EN
    task automatic test_force();
        logic [SEL_W-1:0] exp_sel;
        do_reset();
        out_ready = 1'b1;
        in_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        in_valid = 4'b1111;
        force_en = 1'b1;
        force_sel = SEL_W'(1);
        exp_sel = SEL_W'(1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL force_ready[%0d] got=%b exp=0010", i, in_ready); end
            @(negedge clk);
            $display("force: word %0d sel=%0d data=%h", i, out_sel, out_data);
            checks++; if (out_sel !== exp_sel || out_data !== 32'hE1) begin failures++; $display("FAIL force_word[%0d] got sel=%0d data=%h exp sel=1 data=e1", i, out_sel, out_data); end
        end
        force_en = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL force_ptr_kept got=%b exp=0001", in_ready); end
        force_en = 1'b1;
        force_sel = SEL_W'(5);
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL force_out_of_range got=%b exp=0000", in_ready); end
        force_en = 1'b0;
        in_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_rr_order();
        test_backpressure();
        test_single_channel();
        test_wrap();
        test_idle_ptr();
`ifdef STREAM_MUX_FORCE_SEL_EN
        test_force();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
